// File: rtl/i2s_rx_frame_fifo_if.sv
// Frame-side bundle of the I2S receive framer: word strobe in, stereo frames out.
// The slave modport is the framer itself; the master modport is whoever drives words and sinks frames.
interface i2s_rx_frame_fifo_if #(
  parameter int WORD_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
);
  logic [WORD_WIDTH-1:0]         data_i;
  logic                          lr_chnl_i;
  logic                          write_i;
  logic                          clr_i;
  logic [WORD_WIDTH-1:0]         frame_left_o;
  logic [WORD_WIDTH-1:0]         frame_right_o;
  logic                          frame_valid_o;
  logic                          frame_ready_i;
  logic [$clog2(FIFO_DEPTH):0]   count_o;
  logic                          sync_err_o;
  logic                          overflow_o;

  modport slave (
    input  data_i, lr_chnl_i, write_i, clr_i, frame_ready_i,
    output frame_left_o, frame_right_o, frame_valid_o, count_o, sync_err_o, overflow_o
  );

  modport master (
    output data_i, lr_chnl_i, write_i, clr_i, frame_ready_i,
    input  frame_left_o, frame_right_o, frame_valid_o, count_o, sync_err_o, overflow_o
  );
endinterface

// File: rtl/i2s_rx_frame_fifo.sv
// Pairs left/right channel words into stereo frames and buffers them in a
// fall-through FIFO with sticky channel-order and overflow flags.
module i2s_rx_frame_fifo #(
  parameter int WORD_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  i2s_rx_frame_fifo_if.slave   bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {WAIT_L = 1'b0, HAVE_L = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   left_q, left_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    sync_err_q, sync_err_d;
  logic                    overflow_q, overflow_d;
  logic [2*WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic push_req;
  logic push;
  logic pop;
  logic full;
  logic sync_set;
  logic ovf_set;

  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    push_req = 1'b0;
    sync_set = 1'b0;
    if (bus.write_i) begin
      case (state_q)
        WAIT_L: begin
          if (bus.lr_chnl_i) begin
            sync_set = 1'b1;
          end else begin
            left_d  = bus.data_i;
            state_d = HAVE_L;
          end
        end
        HAVE_L: begin
          if (bus.lr_chnl_i) begin
            push_req = 1'b1;
            state_d  = WAIT_L;
          end else begin
            left_d   = bus.data_i;
            sync_set = 1'b1;
          end
        end
        default: state_d = WAIT_L;
      endcase
    end
  end

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    pop      = (count_q != '0) && bus.frame_ready_i;
    full     = (count_q == DEPTH_C);
    push     = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    sync_err_d = sync_err_q;
    overflow_d = overflow_q;
    if (bus.clr_i) begin
      sync_err_d = 1'b0;
      overflow_d = 1'b0;
    end
    if (sync_set) sync_err_d = 1'b1;
    if (ovf_set)  overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= WAIT_L;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sync_err_q <= sync_err_d;
      overflow_q <= overflow_d;
    end
  end

  // Holding register and frame storage carry no reset; the pointers define validity.
  always_ff @(posedge clk_i) begin
    left_q <= left_d;
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= {left_q, bus.data_i};
    end
  end

  assign bus.frame_left_o  = mem_q[rd_ptr_q][2*WORD_WIDTH-1:WORD_WIDTH];
  assign bus.frame_right_o = mem_q[rd_ptr_q][WORD_WIDTH-1:0];
  assign bus.frame_valid_o = (count_q != '0);
  assign bus.count_o       = count_q;
  assign bus.sync_err_o    = sync_err_q;
  assign bus.overflow_o    = overflow_q;
endmodule
